// File: rtl/sram_arbiter_pkg.sv
// Shared widths, FSM encodings and command payload for the async SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_AW    = 18;
  localparam int unsigned SRAM_BANKW = 1;
  localparam int unsigned SRAM_DW    = 32;
  localparam int unsigned SRAM_BEW   = 4;
  localparam int unsigned REQ_AW     = SRAM_AW + SRAM_BANKW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

  typedef struct packed {
    logic                we;
    logic [REQ_AW-1:0]   addr;
    logic [SRAM_BEW-1:0] be;
    logic [SRAM_DW-1:0]  wdata;
  } sram_cmd_t;

  // Bank bit selects which active-low chip select is pulled down.
  function automatic logic [1:0] bank_cs_n(input logic bank);
    return bank ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 upward with wrap.
// SRAM_ARB_FIXPRIO_EN gives requester 0 absolute priority; others rotate.
module sram_rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh_c,
  output logic [IW-1:0]   win_idx_c,
  output logic            win_vld_c,
  output logic            ptr_upd_c
);

  always_comb begin
    logic [NREQ-1:0] msk;
    int              j;
    logic [IW-1:0]   jj;
    msk       = req;
    win_oh_c  = '0;
    win_idx_c = '0;
    win_vld_c = 1'b0;
    ptr_upd_c = 1'b0;
    j         = 0;
    jj        = '0;
`ifdef SRAM_ARB_FIXPRIO_EN
    // Requester 0 bypasses the rotation and never moves the pointer.
    msk[0] = 1'b0;
    if (req[0]) begin
      win_vld_c = 1'b1;
      win_idx_c = '0;
    end
`endif
    for (int i = 1; i <= int'(NREQ); i++) begin
      j = int'(ptr) + i;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      jj = IW'(j);
      if (!win_vld_c && msk[jj]) begin
        win_vld_c = 1'b1;
        win_idx_c = jj;
        ptr_upd_c = 1'b1;
      end
    end
    if (win_vld_c) win_oh_c[win_idx_c] = 1'b1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Async SRAM arbiter/sequencer: IDLE -> SETUP -> ACCESS(WAIT_CYC) -> END per transaction.
// Optional SRAM_ARB_FIXPRIO_EN gives requester 0 fixed priority (see sram_rr_pick).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*19-1:0]     addr,
  input  logic [NREQ*4-1:0]      be,
  input  logic [NREQ*32-1:0]     wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [31:0]            rdata,
  output logic [NREQ-1:0]        rvalid,
  output logic [17:0]            ram_addr,
  output logic [1:0]             ram_cs_n,
  output logic [3:0]             ram_be_n,
  output logic                   ram_we_n,
  output logic                   ram_rd_n,
  output logic [31:0]            ram_dout,
  output logic                   ram_dout_en,
  input  logic [31:0]            ram_din
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]          state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic [IW-1:0]       cur, cur_nxt;
  sram_cmd_t           cmd, cmd_nxt, req_cmd;

  logic [NREQ-1:0]     win_oh;
  logic [IW-1:0]       win_idx;
  logic                win_vld;
  logic                ptr_upd;

  logic [NREQ-1:0]     gnt_nxt, rvalid_nxt;
  logic [31:0]         rdata_nxt, dout_nxt;
  logic [17:0]         addr_nxt;
  logic [1:0]          cs_n_nxt;
  logic [3:0]          be_n_nxt;
  logic                we_n_nxt, rd_n_nxt, dout_en_nxt;

  sram_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req       (req),
    .ptr       (ptr),
    .win_oh_c  (win_oh),
    .win_idx_c (win_idx),
    .win_vld_c (win_vld),
    .ptr_upd_c (ptr_upd)
  );

  // Command of the current round-robin winner, straight from the request ports.
  always_comb begin
    req_cmd.we    = we[win_idx];
    req_cmd.addr  = addr[int'(win_idx)*REQ_AW +: REQ_AW];
    req_cmd.be    = be[int'(win_idx)*SRAM_BEW +: SRAM_BEW];
    req_cmd.wdata = wdata[int'(win_idx)*SRAM_DW +: SRAM_DW];
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    cur_nxt     = cur;
    cmd_nxt     = cmd;
    gnt_nxt     = '0;
    rvalid_nxt  = '0;
    rdata_nxt   = rdata;
    addr_nxt    = ram_addr;
    cs_n_nxt    = 2'b11;
    be_n_nxt    = 4'hF;
    we_n_nxt    = 1'b1;
    rd_n_nxt    = 1'b1;
    dout_nxt    = ram_dout;
    dout_en_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          state_nxt = ST_SETUP;
          cmd_nxt   = req_cmd;
          cur_nxt   = win_idx;
          gnt_nxt   = win_oh;
          if (ptr_upd) ptr_nxt = win_idx;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
        cnt_nxt   = 4'(WAIT_CYC - 1);
      end
      ST_ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_END;
          if (!cmd.we) begin
            rdata_nxt       = ram_din;
            rvalid_nxt[cur] = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Bus pins follow the phase being entered so they are valid from its first cycle.
    if (state_nxt != ST_IDLE) begin
      addr_nxt = cmd_nxt.addr[SRAM_AW-1:0];
      cs_n_nxt = bank_cs_n(cmd_nxt.addr[REQ_AW-1]);
      be_n_nxt = ~cmd_nxt.be;
      if (cmd_nxt.we) begin
        dout_nxt    = cmd_nxt.wdata;
        dout_en_nxt = 1'b1;
        we_n_nxt    = (state_nxt == ST_ACCESS) ? 1'b0 : 1'b1;
      end else begin
        rd_n_nxt    = (state_nxt == ST_END) ? 1'b1 : 1'b0;
      end
    end
  end

  // State, command latch and registered SRAM pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ptr         <= IW'(NREQ - 1);
      cur         <= '0;
      cmd         <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      ram_addr    <= '0;
      ram_cs_n    <= 2'b11;
      ram_be_n    <= 4'hF;
      ram_we_n    <= 1'b1;
      ram_rd_n    <= 1'b1;
      ram_dout    <= '0;
      ram_dout_en <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ptr         <= ptr_nxt;
      cur         <= cur_nxt;
      cmd         <= cmd_nxt;
      gnt         <= gnt_nxt;
      rvalid      <= rvalid_nxt;
      rdata       <= rdata_nxt;
      ram_addr    <= addr_nxt;
      ram_cs_n    <= cs_n_nxt;
      ram_be_n    <= be_n_nxt;
      ram_we_n    <= we_n_nxt;
      ram_rd_n    <= rd_n_nxt;
      ram_dout    <= dout_nxt;
      ram_dout_en <= dout_en_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural async SRAM and a read scoreboard.
module tb_sram_arbiter;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned WAIT_CYC = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req, we;
  logic [NREQ*19-1:0] addr;
  logic [NREQ*4-1:0] be;
  logic [NREQ*32-1:0] wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [31:0]       rdata, ram_dout, ram_din;
  logic [17:0]       ram_addr;
  logic [1:0]        ram_cs_n;
  logic [3:0]        ram_be_n;
  logic              ram_we_n, ram_rd_n, ram_dout_en;

  typedef struct {
    int unsigned who;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [18:0]];
  int          checks = 0;
  int          failures = 0;

  sram_arbiter #(.NREQ(NREQ), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .ram_addr(ram_addr),
    .ram_cs_n(ram_cs_n), .ram_be_n(ram_be_n), .ram_we_n(ram_we_n), .ram_rd_n(ram_rd_n),
    .ram_dout(ram_dout), .ram_dout_en(ram_dout_en), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // SRAM write: byte-masked store on every clock with xwe_n low and a bank selected.
  always @(posedge clk) begin : sram_wr
    logic [18:0] k;
    logic [31:0] old, m;
    if (!ram_we_n && ram_cs_n != 2'b11) begin
      k   = {~ram_cs_n[1], ram_addr};
      old = mem.exists(k) ? mem[k] : 32'h0;
      m   = {{8{~ram_be_n[3]}}, {8{~ram_be_n[2]}}, {8{~ram_be_n[1]}}, {8{~ram_be_n[0]}}};
      mem[k] = (old & ~m) | (ram_dout & m);
    end
  end

  // SRAM read: data appears half a cycle after xrd_n/cs are seen active.
  always @(negedge clk) begin : sram_rd
    logic [18:0] k;
    k = {~ram_cs_n[1], ram_addr};
    if (!ram_rd_n && ram_cs_n != 2'b11) ram_din <= mem.exists(k) ? mem[k] : 32'h0;
    else ram_din <= 32'h5A5A5A5A;
  end

  task automatic set_cmd(input int i, input logic w, input logic [18:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    we[i]          = w;
    addr[i*19 +: 19] = a;
    be[i*4 +: 4]   = b;
    wdata[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    checks += 5;
    if (gnt !== 3'b000 || rvalid !== 3'b000) begin failures++; $display("FAIL rst_gnt_rvalid got=%b/%b exp=000/000", gnt, rvalid); end
    if (ram_cs_n !== 2'b11 || ram_be_n !== 4'hF) begin failures++; $display("FAIL rst_cs_be got=%b/%h exp=11/f", ram_cs_n, ram_be_n); end
    if (ram_we_n !== 1'b1 || ram_rd_n !== 1'b1) begin failures++; $display("FAIL rst_strobes got=%b/%b exp=1/1", ram_we_n, ram_rd_n); end
    if (ram_addr !== 18'h0 || ram_dout !== 32'h0 || ram_dout_en !== 1'b0) begin failures++; $display("FAIL rst_bus got=%h/%h/%b exp=0/0/0", ram_addr, ram_dout, ram_dout_en); end
    if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || ram_cs_n !== 2'b11) begin failures++; $display("FAIL rst_idle got=%b/%b exp=000/11", gnt, ram_cs_n); end
  endtask

  task automatic test_round_robin();
    int exp_seq [6];
    int cyc, last, n;
`ifdef SRAM_ARB_FIXPRIO_EN
    exp_seq = '{0, 0, 0, 1, 2, 1};
`else
    exp_seq = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 3; i++) set_cmd(i, 1'b1, 19'h00100 + 19'(i), 4'hF, 32'hA0000000 + 32'(i));
    req  = 3'b111;
    cyc  = 0;
    last = 0;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        cyc++;
        n++;
      end while (gnt === 3'b000 && n < 20);
      checks += 3;
      if (gnt === 3'b000) begin failures++; $display("FAIL rr_timeout grant=%0d got=none exp=%0d", g, exp_seq[g]); end
      if ($countones(gnt) > 1) begin failures++; $display("FAIL rr_onehot got=%b exp=single bit", gnt); end
      if (gnt !== (3'b001 << exp_seq[g])) begin failures++; $display("FAIL rr_order grant=%0d got=%b exp=%b", g, gnt, 3'b001 << exp_seq[g]); end
      if (g > 0) begin
        checks++;
        if (cyc - last != int'(WAIT_CYC) + 3) begin failures++; $display("FAIL rr_spacing grant=%0d got=%0d exp=%0d", g, cyc - last, WAIT_CYC + 3); end
      end
      last = cyc;
`ifdef SRAM_ARB_FIXPRIO_EN
      if (g == 2) req[0] = 1'b0;
`endif
    end
    req = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_write();
    logic [2:0] exp_gnt;
    logic [1:0] exp_cs;
    logic       exp_we, exp_en;
    set_cmd(0, 1'b1, 19'h00010, 4'hF, 32'hDEADBEEF);
    req = 3'b001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_gnt = (c == 1) ? 3'b001 : 3'b000;
      exp_cs  = (c <= 4) ? 2'b10 : 2'b11;
      exp_we  = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      exp_en  = (c <= 4);
      checks += 5;
      if (gnt !== exp_gnt) begin failures++; $display("FAIL wr_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      if (ram_cs_n !== exp_cs) begin failures++; $display("FAIL wr_cs cyc=%0d got=%b exp=%b", c, ram_cs_n, exp_cs); end
      if (ram_we_n !== exp_we) begin failures++; $display("FAIL wr_we_n cyc=%0d got=%b exp=%b", c, ram_we_n, exp_we); end
      if (ram_dout_en !== exp_en) begin failures++; $display("FAIL wr_dout_en cyc=%0d got=%b exp=%b", c, ram_dout_en, exp_en); end
      if (ram_rd_n !== 1'b1) begin failures++; $display("FAIL wr_rd_n cyc=%0d got=%b exp=1", c, ram_rd_n); end
      if (c == 1) begin
        checks += 2;
        if (ram_dout !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_dout got=%h exp=deadbeef", ram_dout); end
        if (ram_addr !== 18'h00010) begin failures++; $display("FAIL wr_addr got=%h exp=00010", ram_addr); end
        req = '0;
      end
    end
  endtask

  task automatic test_read();
    exp_t       e;
    logic [2:0] exp_gnt, exp_rv;
    logic       exp_rd;
    set_cmd(1, 1'b0, 19'h00010, 4'hF, 32'h0);
    req = 3'b010;
    sb.push_back('{who: 1, data: 32'hDEADBEEF});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_gnt = (c == 1) ? 3'b010 : 3'b000;
      exp_rd  = (c <= 3) ? 1'b0 : 1'b1;
      exp_rv  = (c == 4) ? 3'b010 : 3'b000;
      checks += 4;
      if (gnt !== exp_gnt) begin failures++; $display("FAIL rd_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      if (ram_rd_n !== exp_rd) begin failures++; $display("FAIL rd_rd_n cyc=%0d got=%b exp=%b", c, ram_rd_n, exp_rd); end
      if (ram_dout_en !== 1'b0) begin failures++; $display("FAIL rd_dout_en cyc=%0d got=%b exp=0", c, ram_dout_en); end
      if (rvalid !== exp_rv) begin failures++; $display("FAIL rd_rvalid cyc=%0d got=%b exp=%b", c, rvalid, exp_rv); end
      if (c == 1) req = '0;
      if (rvalid !== 3'b000 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdata !== e.data) begin failures++; $display("FAIL rd_data got=%h exp=%h", rdata, e.data); end
      end
      if (c == 5) begin
        checks++;
        if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold got=%h exp=deadbeef", rdata); end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rd_sb_left got=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_bank();
    logic [18:0] a [2];
    logic [3:0]  b [2];
    logic [31:0] d [2];
    logic [1:0]  cs [2];
    logic [17:0] ra [2];
    exp_t        e;
    int          n;
    a  = '{19'h40000, 19'h3FFFF};
    b  = '{4'h3, 4'hF};
    d  = '{32'h11111111, 32'h22222222};
    cs = '{2'b01, 2'b10};
    ra = '{18'h00000, 18'h3FFFF};
    for (int t = 0; t < 2; t++) begin
      set_cmd(0, 1'b1, a[t], b[t], d[t]);
      req = 3'b001;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt === 3'b000 && n < 20);
      req = '0;
      checks += 4;
      if (gnt !== 3'b001) begin failures++; $display("FAIL bank_gnt t=%0d got=%b exp=001", t, gnt); end
      if (ram_cs_n !== cs[t]) begin failures++; $display("FAIL bank_cs t=%0d got=%b exp=%b", t, ram_cs_n, cs[t]); end
      if (ram_addr !== ra[t]) begin failures++; $display("FAIL bank_addr t=%0d got=%h exp=%h", t, ram_addr, ra[t]); end
      if (ram_be_n !== ~b[t]) begin failures++; $display("FAIL bank_be_n t=%0d got=%h exp=%h", t, ram_be_n, ~b[t]); end
      repeat (4) @(negedge clk);
    end
    // Only the two low bytes of bank 1 word 0 were enabled.
    set_cmd(2, 1'b0, 19'h40000, 4'hF, 32'h0);
    req = 3'b100;
    sb.push_back('{who: 2, data: 32'h00001111});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (gnt !== 3'b000) req = '0;
    end while (rvalid === 3'b000 && n < 20);
    checks++;
    if (rvalid === 3'b000) begin failures++; $display("FAIL bank_rd_timeout got=none exp=rvalid"); end
    else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rvalid !== (3'b001 << e.who) || rdata !== e.data) begin
        failures++; $display("FAIL bank_rd got=%b/%h exp=%b/%h", rvalid, rdata, 3'b001 << e.who, e.data);
      end
    end
    sb.delete();
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int n;
    set_cmd(2, 1'b0, 19'h00010, 4'hF, 32'h0);
    req = 3'b100;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt === 3'b000 && n < 20);
    req = '0;
    @(negedge clk);
    checks++;
    if (ram_rd_n !== 1'b0) begin failures++; $display("FAIL rm_pre_rd_n got=%b exp=0", ram_rd_n); end
    reset_n = 1'b0;
    #1;
    checks += 2;
    if (ram_rd_n !== 1'b1 || ram_cs_n !== 2'b11) begin failures++; $display("FAIL rm_strobes got=%b/%b exp=1/11", ram_rd_n, ram_cs_n); end
    if (ram_dout_en !== 1'b0 || gnt !== 3'b000) begin failures++; $display("FAIL rm_bus got=%b/%b exp=0/000", ram_dout_en, gnt); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 3'b000) begin failures++; $display("FAIL rm_rvalid_in_reset got=%b exp=000", rvalid); end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) set_cmd(i, 1'b1, 19'h00200 + 19'(i), 4'hF, 32'h0);
    req = 3'b111;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++;
      if (rvalid !== 3'b000) begin failures++; $display("FAIL rm_rvalid_after got=%b exp=000", rvalid); end
    end while (gnt === 3'b000 && n < 20);
    req = '0;
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL rm_first_gnt got=%b exp=001", gnt); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 3'b000) begin failures++; $display("FAIL rm_rvalid_wr got=%b exp=000", rvalid); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    we      = '0;
    addr    = '0;
    be      = '0;
    wdata   = '0;
    ram_din = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_write();
    test_read();
    test_bank();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
